// File: rtl/wb_ram_burst.sv
// wb_ram_burst: Wishbone B3 RAM slave with byte-lane writes, registered reads and incrementing/wrapping bursts
module wb_ram_burst #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 512,
    parameter int ADDR_WIDTH = 11
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic [ADDR_WIDTH-1:0]   adr_i,
    input  logic [DATA_WIDTH-1:0]   dat_i,
    input  logic [DATA_WIDTH/8-1:0] sel_i,
    input  logic                    we_i,
    input  logic                    cyc_i,
    input  logic                    stb_i,
    input  logic [2:0]              cti_i,
    input  logic [1:0]              bte_i,
    output logic                    ack_o,
    output logic                    err_o,
    output logic [DATA_WIDTH-1:0]   dat_o
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int LSB = (BYTES > 1) ? $clog2(BYTES) : 0;
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_A = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, CLASSIC, BURST} state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         cur_adr;
    logic [ADDR_WIDTH-1:0] word;
    logic [AW:0]           cur_inc;
    logic [AW:0]           wrap_mask;
    logic [AW:0]           nxt;
    logic                  word_ok;
    logic                  nxt_ok;
    logic                  beat;

    // Address decode and next-beat address; nxt carries one extra bit so a linear step past the end is visible
    always_comb begin
        word      = adr_i >> LSB;
        word_ok   = {1'b0, word} < DEPTH_A;
        cur_inc   = {1'b0, cur_adr} + (AW + 1)'(1);
        wrap_mask = bte_i == 2'b01 ? (AW + 1)'(3) : bte_i == 2'b10 ? (AW + 1)'(7) : (AW + 1)'(15);
        nxt       = bte_i == 2'b00 ? cur_inc : (({1'b0, cur_adr} & ~wrap_mask) | (cur_inc & wrap_mask));
        nxt_ok    = nxt < DEPTH_W;
        beat      = ack_o & cyc_i & stb_i;
    end

    // Byte-lane write commit on each completing beat; reset gates ack_o so no beat commits during reset
    always_ff @(posedge clk_i) begin
        if (beat && we_i)
            for (int n = 0; n < BYTES; n++)
                if (sel_i[n]) mem[cur_adr][8*n +: 8] <= dat_i[8*n +: 8];
    end

    // Bus FSM: error is a one-cycle pulse, cleared on the edge it is seen so a held strobe cannot retrigger it
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state   <= IDLE;
            cur_adr <= '0;
            ack_o   <= 1'b0;
            err_o   <= 1'b0;
            dat_o   <= '0;
        end else if (!cyc_i) begin
            state <= IDLE;
            ack_o <= 1'b0;
            err_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ack_o <= 1'b0;
                    err_o <= 1'b0;
                    if (stb_i && !err_o) begin
                        if (!word_ok) err_o <= 1'b1;
                        else begin
                            ack_o   <= 1'b1;
                            cur_adr <= word[AW-1:0];
                            dat_o   <= mem[word[AW-1:0]];
                            state   <= cti_i == 3'b010 ? BURST : CLASSIC;
                        end
                    end
                end
                CLASSIC: begin
                    ack_o <= 1'b0;
                    state <= IDLE;
                end
                BURST: begin
                    if (ack_o) begin
                        if (!stb_i) ack_o <= 1'b0;
                        else if (cti_i == 3'b111) begin
                            ack_o <= 1'b0;
                            state <= IDLE;
                        end else if (!nxt_ok) begin
                            ack_o <= 1'b0;
                            err_o <= 1'b1;
                            state <= IDLE;
                        end else begin
                            cur_adr <= nxt[AW-1:0];
                            dat_o   <= mem[nxt[AW-1:0]];
                        end
                    end else if (stb_i) begin
                        ack_o <= 1'b1;
                        dat_o <= mem[cur_adr];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wb_ram_burst.sv
// tb_wb_ram_burst: randomized scoreboard bench for the Wishbone burst RAM against a word-array model
module tb_wb_ram_burst;
    localparam int DW = 32;
    localparam int DEPTH = 40;
    localparam int AW = 8;

    typedef struct {
        bit          err;
        bit          chk;
        logic [31:0] data;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] adr;
    logic [DW-1:0] wdat;
    logic [3:0]    sel;
    logic          we;
    logic          cyc;
    logic          stb;
    logic [2:0]    cti;
    logic [1:0]    bte;
    logic          ack;
    logic          err;
    logic [DW-1:0] rdat;

    exp_t        sbq[$];
    logic [31:0] mdl [64];
    int          checks = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    wb_ram_burst #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .adr_i(adr), .dat_i(wdat), .sel_i(sel), .we_i(we),
        .cyc_i(cyc), .stb_i(stb), .cti_i(cti), .bte_i(bte), .ack_o(ack), .err_o(err), .dat_o(rdat)
    );

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endfunction

    function automatic void mwrite(int w, logic [31:0] d, logic [3:0] s);
        for (int n = 0; n < 4; n++)
            if (s[n]) mdl[w][8*n +: 8] = d[8*n +: 8];
    endfunction

    function automatic int wnext(int a, logic [1:0] b);
        int m;
        m = b == 2'd1 ? 3 : b == 2'd2 ? 7 : b == 2'd3 ? 15 : 0;
        return b == 2'd0 ? a + 1 : ((a & ~m) | ((a + 1) & m));
    endfunction

    function automatic void expect_resp(bit is_err, bit chk, logic [31:0] d);
        exp_t e;
        e.err = is_err;
        e.chk = chk;
        e.data = d;
        sbq.push_back(e);
    endfunction

    task automatic drive(bit w_en, int wa, logic [31:0] d, logic [3:0] s, logic [2:0] c, logic [1:0] b);
        cyc = 1'b1; stb = 1'b1; we = w_en; adr = AW'(wa * 4); wdat = d; sel = s; cti = c; bte = b;
    endtask

    task automatic wait_resp(string name, int lat);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(ack || err) && n < 20);
        check(name, n, lat);
    endtask

    task automatic classic(bit w_en, int w, logic [31:0] d, logic [3:0] s);
        bit oor;
        logic [2:0] c;
        oor = w >= DEPTH;
        expect_resp(oor, !w_en && !oor, oor ? 32'h0 : mdl[w]);
        if (w_en && !oor) mwrite(w, d, s);
        c = 3'($urandom_range(0, 7));
        if (c == 3'b010) c = 3'b000;
        @(posedge clk); #1;
        drive(w_en, w, d, s, c, 2'($urandom_range(0, 3)));
        wait_resp("classic_latency", 2);
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        check("classic_gap", {30'b0, ack, err}, 32'h0);
    endtask

    // mode 0: normal end with cti=111, 1: cyc dropped after nb beats, 2: reset while beat nb is presented
    task automatic burst(bit w_en, int start, logic [1:0] b, int nb, int stall_at, int mode, bit full);
        int          a;
        int          nd;
        bit          erred;
        bit          stl;
        int          addrs[$];
        logic [31:0] ds[$];
        logic [3:0]  ss[$];
        a = start; nd = nb; erred = 1'b0;
        for (int i = 0; i < nb; i++) begin
            addrs.push_back(a);
            ds.push_back($urandom);
            ss.push_back(full ? 4'hF : 4'($urandom));
            if (a >= DEPTH) begin
                expect_resp(1'b1, 1'b0, 32'h0);
                nd = i + 1;
                erred = 1'b1;
                break;
            end
            expect_resp(1'b0, !w_en, mdl[a]);
            if (w_en) mwrite(a, ds[i], ss[i]);
            a = wnext(a, b);
        end
        addrs.push_back(a); ds.push_back($urandom); ss.push_back(4'hF);
        for (int i = 0; i < nd; i++) begin
            stl = i == stall_at && i > 0 && !(erred && i == nd - 1);
            @(posedge clk); #1;
            if (stl) begin
                stb = 1'b0;
                repeat (2) @(posedge clk);
                #1;
            end
            drive(w_en, addrs[i], ds[i], ss[i], (mode == 0 && i == nb - 1) ? 3'b111 : 3'b010, b);
            wait_resp("burst_latency", (i == 0 || stl) ? 2 : 1);
        end
        if (mode == 0) begin
            @(posedge clk); #1;
            cyc = 1'b0; stb = 1'b0;
            @(negedge clk);
            check("burst_end", {30'b0, ack, err}, 32'h0);
        end else if (mode == 1) begin
            @(posedge clk); #1;
            cyc = 1'b0; stb = 1'b0;
            repeat (2) @(negedge clk);
            check("abort_clean", {30'b0, ack, err}, 32'h0);
        end else begin
            @(posedge clk); #1;
            drive(w_en, addrs[nd], ds[nd], ss[nd], 3'b010, b);
            #2 rst_n = 1'b0;
            #1;
            check("reset_async_flags", {30'b0, ack, err}, 32'h0);
            check("reset_async_dat", rdat, 32'h0);
            cyc = 1'b0; stb = 1'b0;
            repeat (2) @(negedge clk);
            check("reset_hold_flags", {30'b0, ack, err}, 32'h0);
            check("reset_hold_dat", rdat, 32'h0);
            @(posedge clk); #1;
            rst_n = 1'b1;
        end
    endtask

    // Scoreboard monitor: a response is a completing ack beat or an error pulse
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            check("ack_err_exclusive", {31'b0, ack & err}, 32'h0);
            if (err || (ack && cyc && stb)) begin
                if (sbq.size() == 0) check("unexpected_response", {30'b0, ack, err}, 32'h0);
                else begin
                    e = sbq.pop_front();
                    check("resp_kind", {31'b0, err}, {31'b0, e.err});
                    if (e.chk) check("read_data", rdat, e.data);
                end
            end
        end
    end

    initial begin
        int b_nb;
        int b_st;
        int b_stall;
        logic [1:0] b_bte;
        cyc = 0; stb = 0; we = 0; adr = '0; wdat = '0; sel = '0; cti = '0; bte = '0; rst_n = 1'b0;
        for (int i = 0; i < 64; i++) mdl[i] = 'x;
        repeat (2) @(negedge clk);
        check("reset_ack", {31'b0, ack}, 32'h0);
        check("reset_err", {31'b0, err}, 32'h0);
        check("reset_dat", rdat, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        burst(1'b1, 0, 2'b00, DEPTH, -1, 0, 1'b1);
        classic(1'b1, 4, 32'hDEADBEEF, 4'hF);
        classic(1'b0, 4, 32'h0, 4'h0);
        classic(1'b1, 5, 32'h11223344, 4'hF);
        classic(1'b1, 5, 32'h000000AA, 4'h1);
        classic(1'b0, 5, 32'h0, 4'h0);
        burst(1'b0, 8, 2'b00, 4, -1, 0, 1'b0);
        burst(1'b1, 6, 2'b01, 4, -1, 0, 1'b1);
        for (int w = 4; w <= 8; w++) classic(1'b0, w, 32'h0, 4'h0);
        classic(1'b0, DEPTH, 32'h0, 4'h0);
        burst(1'b0, DEPTH - 2, 2'b00, 4, -1, 0, 1'b0);
        burst(1'b0, 2, 2'b00, 5, 2, 0, 1'b0);
        burst(1'b1, 20, 2'b00, 3, -1, 1, 1'b1);
        burst(1'b1, 12, 2'b10, 3, -1, 2, 1'b1);
        for (int w = 12; w <= 15; w++) classic(1'b0, w, 32'h0, 4'h0);
        for (int w = 20; w <= 23; w++) classic(1'b0, w, 32'h0, 4'h0);
        repeat (40) begin
            if ($urandom_range(0, 1) == 1)
                classic(1'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH + 3)), $urandom, 4'($urandom));
            else begin
                b_bte = 2'($urandom_range(0, 3));
                b_nb = int'($urandom_range(1, 6));
                b_st = b_bte == 2'b00 ? int'($urandom_range(0, DEPTH - 1)) : int'($urandom_range(0, 31));
                b_stall = (b_nb > 1 && $urandom_range(0, 2) == 0) ? int'($urandom_range(1, b_nb - 1)) : -1;
                burst(1'($urandom_range(0, 1)), b_st, b_bte, b_nb, b_stall, 0, 1'b0);
            end
        end
        repeat (5) @(negedge clk);
        check("scoreboard_drain", 32'(sbq.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
